// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO with flush and occupancy count.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: none internally; the caller must not push when full without a pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> ((count != CW'(DEPTH)) || pop));

endmodule

// File: rtl/fetch.sv
// Purpose: RV32I fetch; issues word requests, buffers {pc, insn}, flushes on redirect.
// Latency: response to insn_valid is 1 cycle; first insn appears 2 cycles after first accept.
// Backpressure: requests are credit-limited so in-flight plus buffered words never exceed DEPTH.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   resp_pc;
    logic          credit_ok;
    logic          req_fire;
    logic          resp_keep;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = rst_n && !redirect && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses for requests issued before a redirect are counted off by drop.
    assign resp_keep  = imem_resp_valid && !redirect && (drop == '0);
    assign push_entry = '{pc: resp_pc, insn: imem_resp_data};

    // The pcq occupancy is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (req_fire),
        .push_dat (pc),
        .pop      (imem_resp_valid),
        .head_dat (resp_pc),
        .count    (outstanding)
    );

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (resp_keep),
        .push_dat (push_entry),
        .pop      (insn_valid && insn_ready),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    assign insn_valid = (fifo_count != '0);
    assign insn       = head_entry.insn;
    assign insn_pc    = head_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else if (redirect) begin
            pc   <= word_align(redirect_pc);
            // Every request still in flight after this cycle is stale.
            drop <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (imem_resp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding != '0));

endmodule
